// File: rtl/mem_access_ctrl_if.sv
// Bundles the CPU request/response channel and the word-memory port of the
// memory access controller.
//   master : request/memory-data side (CPU and memory model)
//   slave  : controller side
// Signals:
//   req_valid/req_ready, req_write, req_size, req_signed, req_addr, req_wdata
//   resp_valid, resp_rdata, resp_error
//   mem_write_enable, mem_read_enable, mem_addr, mem_wdata, mem_rdata
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_write_enable, mem_read_enable, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_write_enable, mem_read_enable, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a CPU request channel and a 32-bit word
// memory. Handles byte/halfword/word accesses with little-endian lanes,
// sign/zero extension of loads, read-modify-write for sub-word stores and
// alignment errors.
// Ports:
//   clk   : system clock, rising-edge state updates
//   reset : asynchronous active-low reset
//   bus   : request/response and memory signals (slave modport)
module mem_access_ctrl (
    input  logic                clk,
    input  logic                reset,
    mem_access_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_lane;
    logic [15:0] lat_wdata;

    logic        req_error;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_word;
    logic [31:0] merge_word;

    // Misaligned or illegal-size requests are rejected without touching memory.
    always_comb begin
        req_error = 1'b0;
        case (bus.req_size)
            2'b00:   req_error = 1'b0;
            2'b01:   req_error = bus.req_addr[0];
            2'b10:   req_error = (bus.req_addr[1:0] != 2'b00);
            default: req_error = 1'b1;
        endcase
    end

    // Lane extraction for loads and lane insertion for sub-word stores, both
    // working on the word currently presented by memory.
    always_comb begin
        byte_sel = 8'h00;
        case (lat_lane)
            2'd0: byte_sel = bus.mem_rdata[7:0];
            2'd1: byte_sel = bus.mem_rdata[15:8];
            2'd2: byte_sel = bus.mem_rdata[23:16];
            2'd3: byte_sel = bus.mem_rdata[31:24];
        endcase
        half_sel = lat_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        case (lat_size)
            2'b00:   load_word = {{24{lat_signed & byte_sel[7]}}, byte_sel};
            2'b01:   load_word = {{16{lat_signed & half_sel[15]}}, half_sel};
            default: load_word = bus.mem_rdata;
        endcase

        merge_word = bus.mem_rdata;
        if (lat_size == 2'b00) begin
            case (lat_lane)
                2'd0: merge_word[7:0]   = lat_wdata[7:0];
                2'd1: merge_word[15:8]  = lat_wdata[7:0];
                2'd2: merge_word[23:16] = lat_wdata[7:0];
                2'd3: merge_word[31:24] = lat_wdata[7:0];
            endcase
        end else if (lat_lane[1]) begin
            merge_word[31:16] = lat_wdata;
        end else begin
            merge_word[15:0] = lat_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= IDLE;
            bus.req_ready        <= 1'b1;
            bus.resp_valid       <= 1'b0;
            bus.resp_error       <= 1'b0;
            bus.resp_rdata       <= '0;
            bus.mem_write_enable <= 1'b0;
            bus.mem_read_enable  <= 1'b0;
            bus.mem_addr         <= '0;
            bus.mem_wdata        <= '0;
            lat_write            <= 1'b0;
            lat_size             <= '0;
            lat_signed           <= 1'b0;
            lat_lane             <= '0;
            lat_wdata            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        lat_write     <= bus.req_write;
                        lat_size      <= bus.req_size;
                        lat_signed    <= bus.req_signed;
                        lat_lane      <= bus.req_addr[1:0];
                        lat_wdata     <= bus.req_wdata[15:0];
                        bus.req_ready <= 1'b0;
                        // No range check: upper address bits pass straight through.
                        bus.mem_addr  <= {2'b00, bus.req_addr[31:2]};
                        if (req_error) begin
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                            bus.resp_rdata <= '0;
                            state          <= RESP;
                        end else if (!bus.req_write || bus.req_size != 2'b10) begin
                            // Loads and sub-word stores both need the current word.
                            bus.mem_read_enable <= 1'b1;
                            state               <= READ;
                        end else begin
                            bus.mem_wdata        <= bus.req_wdata;
                            bus.mem_write_enable <= 1'b1;
                            state                <= WRITE;
                        end
                    end
                end
                READ: begin
                    bus.mem_read_enable <= 1'b0;
                    if (lat_write) begin
                        bus.mem_wdata        <= merge_word;
                        bus.mem_write_enable <= 1'b1;
                        state                <= WRITE;
                    end else begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= 1'b0;
                        bus.resp_rdata <= load_word;
                        state          <= RESP;
                    end
                end
                WRITE: begin
                    bus.mem_write_enable <= 1'b0;
                    bus.resp_valid       <= 1'b1;
                    bus.resp_error       <= 1'b0;
                    bus.resp_rdata       <= '0;
                    state                <= RESP;
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_error <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, multi-cycle
// corner sequences (reset during RMW, held req_valid) and randomized requests
// against a byte-addressed reference memory.
module tb_mem_access_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory seen by the DUT: writes land on the falling edge.
    logic [31:0] mem [256] = '{default: '0};
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_word;

    always @(negedge clk) begin
        if (bus.mem_write_enable)
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        else if (pre_en)
            mem[pre_idx] <= pre_word;
    end
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    // Reference: flat little-endian byte array aliasing the same 1 KiB.
    logic [7:0] ref_bytes [1024] = '{default: '0};

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pre;
        logic [31:0] pre_addr;
        logic [31:0] pre_word;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        int unsigned nb;
        nb = 32'd1 << sz;
        return (sz == 2'b11) || ((a % nb) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int unsigned nb;
        logic [63:0] v;
        nb = 32'd1 << sz;
        v  = '0;
        for (int unsigned i = 0; i < nb; i++)
            v = v | (64'(ref_bytes[(a % 1024) + i]) << (8 * i));
        if (sg && nb < 4 && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1)
            v = v | ~((64'd1 << (8 * nb)) - 64'd1);
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int unsigned base;
        base = (a % 1024) & ~32'd3;
        return {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int unsigned nb;
        logic [31:0] sh;
        nb = 32'd1 << sz;
        for (int unsigned i = 0; i < nb; i++) begin
            sh = wd >> (8 * i);
            ref_bytes[(a % 1024) + i] = sh[7:0];
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        logic [31:0] wa;
        wa       = a & ~32'd3;
        pre_idx  = wa[9:2];
        pre_word = w;
        pre_en   = 1'b1;
        @(negedge clk);
        #1;
        pre_en = 1'b0;
        model_store(wa, 2'b10, w);
    endtask

    // Issues one request, follows it to its response and checks the memory side.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int          n_re;
        int          n_we;
        logic        overlap;
        logic        merr;
        logic [31:0] exp_word;
        merr     = model_err(sz, a);
        exp_word = '0;
        if (w && !merr) begin
            model_store(a, sz, wd);
            exp_word = model_word(a);
        end
        @(negedge clk);
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        chk("ready_before_accept", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0; n_re = 0; n_we = 0; overlap = 1'b0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.mem_read_enable && bus.mem_write_enable) overlap = 1'b1;
            if (bus.mem_read_enable) begin
                n_re++;
                chk("read_mem_addr", 64'(bus.mem_addr), 64'(a >> 2));
            end
            if (bus.mem_write_enable) begin
                n_we++;
                chk("write_mem_addr", 64'(bus.mem_addr), 64'(a >> 2));
                chk("write_mem_wdata", 64'(bus.mem_wdata), 64'(exp_word));
            end
            if (bus.resp_valid) begin
                lat = c;
                rd  = bus.resp_rdata;
                er  = bus.resp_error;
                chk("ready_in_resp", 64'(bus.req_ready), 64'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("resp_seen", 64'(lat != 0), 64'd1);
        chk("enable_overlap", 64'(overlap), 64'd0);
        chk("read_enable_cycles", 64'(n_re), merr ? 64'd0 : ((!w || sz != 2'b10) ? 64'd1 : 64'd0));
        chk("write_enable_cycles", 64'(n_we), (!merr && w) ? 64'd1 : 64'd0);
        @(posedge clk);
        #1;
        chk("ready_after_resp", 64'(bus.req_ready), 64'd1);
        chk("resp_valid_pulse", 64'(bus.resp_valid), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        saw;
        logic [31:0] exp_rd;
        int          resp_cyc[$];
        logic [31:0] resp_dat[$];
        int          n_re;

        checks = 0; errors = 0;
        pre_en = 1'b0; pre_idx = '0; pre_word = '0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = '0;
        bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        // Directed table
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 1'b1, 32'h04, 32'h1012_0000, 32'h1012_0000, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h0000_0003, 32'h0, 1'b1, 32'h00, 32'h8512_0000, 32'hFFFF_FF85, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 1'b0, 32'h00, 32'h0, 32'h0000_0085, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_0016, 32'h0000_ABCD, 1'b1, 32'h14, 32'h1e13_0000, 32'h0, 1'b0, 3});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'h0, 32'h0, 32'hABCD_0000, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_0001, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_0016, 32'h0, 1'b0, 32'h0, 32'h0, 32'hFFFF_ABCD, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0000_0014, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0000_0021, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0000_00BE, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h0000_0022, 32'hFFFF_FF11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 3});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0, 32'h0, 32'hDE11_BEEF, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 1'b0, 32'h0, 32'h0, 32'hDE11_BEEF, 1'b0, 2});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h0000_0023, 32'h0000_1234, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0, 32'h0, 32'hDE11_BEEF, 1'b0, 2});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0, 1'b0, 32'h0, 32'h0, 32'hFFFF_DE11, 1'b0, 2});

        // Reset state, observed while reset is held low
        reset = 1'b0;
        #12;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_error", 64'(bus.resp_error), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_write_enable), 64'd0);
        chk("rst_mem_re", 64'(bus.mem_read_enable), 64'd0);
        chk("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            if (vecs[i].pre) preload(vecs[i].pre_addr, vecs[i].pre_word);
            do_req(vecs[i].write, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
            chk($sformatf("vec%0d_error", i), 64'(er), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // Reset asserted during the WRITE cycle of a byte store
        preload(32'h40, 32'h1122_3344);
        @(negedge clk);
        bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 32'h41; bus.req_wdata = 32'hAA; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 4 && !saw; c++) begin
            @(posedge clk);
            #1;
            saw = bus.mem_write_enable;
        end
        chk("rmw_reached_write", 64'(saw), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_we_drop", 64'(bus.mem_write_enable), 64'd0);
        chk("abort_ready", 64'(bus.req_ready), 64'd1);
        chk("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("abort_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("abort_mem_addr", 64'(bus.mem_addr), 64'd0);
        saw = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) saw = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) saw = 1'b1;
        end
        chk("abort_no_response", 64'(saw), 64'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
        chk("after_abort_rdata", 64'(rd), 64'h1122_3344);
        chk("after_abort_error", 64'(er), 64'd0);
        chk("after_abort_latency", 64'(lat), 64'd2);

        // req_valid held across two loads
        preload(32'h50, 32'hCAFE_0001);
        preload(32'h54, 32'hCAFE_0002);
        @(negedge clk);
        bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
        bus.req_addr = 32'h50; bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        n_re = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 1) bus.req_addr = 32'h54;
            if (c == 4) bus.req_valid = 1'b0;
            if (bus.mem_read_enable) n_re++;
            if (bus.resp_valid) begin
                resp_cyc.push_back(c);
                resp_dat.push_back(bus.resp_rdata);
            end
            @(posedge clk);
            #1;
        end
        chk("held_resp_count", 64'(resp_cyc.size()), 64'd2);
        chk("held_read_count", 64'(n_re), 64'd2);
        if (resp_cyc.size() == 2) begin
            chk("held_first_cycle", 64'(resp_cyc[0]), 64'd2);
            chk("held_second_cycle", 64'(resp_cyc[1]), 64'd5);
            chk("held_first_rdata", 64'(resp_dat[0]), 64'hCAFE_0001);
            chk("held_second_rdata", 64'(resp_dat[1]), 64'hCAFE_0002);
        end
        chk("held_ready_end", 64'(bus.req_ready), 64'd1);

        // Randomized requests against the reference byte memory
        for (int n = 0; n < 300; n++) begin
            logic        w;
            logic [1:0]  sz;
            logic        sg;
            logic [31:0] a;
            logic [31:0] wd;
            if ($urandom_range(0, 9) == 0)
                preload(32'($urandom_range(0, 1023)), $urandom);
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) a = a | ($urandom & 32'hFFFF_FC00);
            wd = $urandom;
            if (model_err(sz, a) || w) exp_rd = '0;
            else                       exp_rd = model_load(a, sz, sg);
            do_req(w, sz, sg, a, wd, rd, er, lat);
            chk("rand_rdata", 64'(rd), 64'(exp_rd));
            chk("rand_error", 64'(er), 64'(model_err(sz, a)));
            chk("rand_latency", 64'(lat),
                model_err(sz, a) ? 64'd1 : ((!w || sz == 2'b10) ? 64'd2 : 64'd3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port req_valid, input, 1: CPU load/store request present.
REQ-004 SHALL have port req_ready, output, 1: controller able to accept a request.
REQ-005 SHALL have port req_write, input, 1: 1=store, 0=load.
REQ-006 SHALL have port req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SHALL have port req_signed, input, 1: sign-extend sub-word loads when 1.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32: load result.
REQ-012 SHALL have port resp_error, output, 1: request rejected; qualified by resp_valid.
REQ-013 SHALL have port mem_write_enable, output, 1: word-memory write strobe.
REQ-014 SHALL have port mem_read_enable, output, 1: word-memory read enable.
REQ-015 SHALL have port mem_addr, output, 32: word index = {2'b00, addr[31:2]}.
REQ-016 SHALL have port mem_wdata, output, 32: word written to memory.
REQ-017 SHALL have port mem_rdata, input, 32: combinational read word from memory.

Function
REQ-018 SHALL implement states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-019 SHALL accept a request on a rising edge with req_valid && req_ready, latching write, size, signed, addr, wdata.
REQ-020 SHALL flag an error if size=11, or halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-021 SHALL sequence per accepted request: error -> RESP; load -> READ -> RESP; word store -> WRITE -> RESP; byte/half store -> READ -> WRITE -> RESP; RESP -> IDLE always.
REQ-022 SHALL give latency from the acceptance edge: resp_valid in cycle 1 (error), 2 (load, word store), 3 (sub-word store).
REQ-023 SHALL assert mem_read_enable only in READ and mem_write_enable only in WRITE, each for exactly one cycle, never both at once, and neither for an errored request.
REQ-024 SHALL hold mem_addr and mem_wdata stable for the whole READ and WRITE cycle, since memory samples writes on the falling clock edge.
REQ-025 SHALL capture mem_rdata at the rising edge ending READ.
REQ-026 SHALL use little-endian lanes: byte lane = addr[1:0] (lane 0 = bits[7:0]); half lane = addr[1] (0 = bits[15:0]).
REQ-027 SHALL zero- or sign-extend loaded byte/half per the latched signed bit; word loads pass through.
REQ-028 SHALL, for sub-word stores, write the captured word with only the addressed lane replaced by req_wdata's low byte/half.
REQ-029 SHALL drive resp_rdata=0 for stores and errors; resp_rdata holds its value outside RESP.
REQ-030 SHALL drive resp_error=0 on every non-error response.
REQ-031 SHALL pass mem_addr bits above the memory depth unchanged, with no range check and no error.
REQ-032 SHALL ignore req_valid outside IDLE; a held req_valid is accepted again at the first IDLE edge after RESP.

Reset
REQ-033 SHALL, while reset=0, immediately force state=IDLE and drive req_ready=1; resp_valid, resp_error, mem_write_enable and mem_read_enable=0; resp_rdata, mem_addr and mem_wdata=0.
REQ-034 SHALL abort any in-flight request on reset assertion with no response; an interrupted RMW leaves memory unmodified unless its falling edge already occurred.

Verification
REQ-035 SHALL pass: lw 0x0000_0004, mem word1=0x1012_0000 -> mem_addr=1, read_enable 1 cycle, resp_valid 2 cycles after accept, resp_rdata=0x1012_0000, error=0.
REQ-036 SHALL pass: lb 0x0000_0003, word0=0x8512_0000 -> signed 0xFFFF_FF85; unsigned 0x0000_0085.
REQ-037 SHALL pass: sh 0x0000_0016 data 0x0000_ABCD, word5=0x1e13_0000 -> READ then WRITE mem_wdata=0xABCD_0000; later lw 0x14 returns 0xABCD_0000.
REQ-038 SHALL pass: lw 0x0000_0002 and size=11 -> resp_valid 1 cycle after accept, resp_error=1, rdata=0, no enable asserted.
REQ-039 SHALL pass: reset low during WRITE of sb -> write_enable drops asynchronously, no resp_valid, req_ready=1; next lw completes normally.
REQ-040 SHALL pass: req_valid held high for two lw -> second accepted only in IDLE after first RESP, no request lost or duplicated.
